// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state types and opcode legality helper for alu_pipe
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_MUL  = 4'b1010
    } alu_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] ma;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mb;
    logic [SHW-1:0]     cnt;

    always_comb begin
        acc_next = mb[0] ? acc + ma : acc;
        product  = acc_next;
        done     = run && (cnt == SHW'(WIDTH - 1));
    end

    // The bit-0 partial product is folded into the start cycle so the final
    // partial product lands exactly on the cycle done is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma  <= '0;
            mb  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            ma  <= {{WIDTH{1'b0}}, a} << 1;
            mb  <= b >> 1;
            acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt <= SHW'(1);
        end else if (run) begin
            acc <= acc_next;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + SHW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked, registered ALU with flags and multi-cycle multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    alu_state_e         state_next;
    logic               accept;
    logic               mul_start;
    logic               mul_run;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c;
    logic               ovf_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mul_start) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && (!out_valid || out_ready);
        mul_run  = (state == MUL_BUSY);
    end

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .run     (mul_run),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // diff[WIDTH] is the borrow of the unsigned subtraction
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shamt   = b[SHW-1:0];
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op)
            OP_ADD: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff[WIDTH-1:0];
                carry_c = diff[WIDTH];
                ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_SLL:  res_c = a << shamt;
            OP_SRL:  res_c = a >> shamt;
            OP_SRA:  res_c = $signed(a) >>> shamt;
            OP_SLT:  res_c[0] = $signed(a) < $signed(b);
            OP_SLTU: res_c[0] = a < b;
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !mul_start) begin
            out_valid <= 1'b1;
            result    <= res_c;
            zero      <= (res_c == '0);
            neg       <= res_c[WIDTH-1];
            carry     <= carry_c;
            ovf       <= ovf_c;
            illegal   <= !is_legal_op(op);
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_prod[WIDTH-1:0];
            zero      <= (mul_prod[WIDTH-1:0] == '0);
            neg       <= mul_prod[WIDTH-1];
            carry     <= 1'b0;
            ovf       <= |mul_prod[2*WIDTH-1:WIDTH];
            illegal   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH=32 and WIDTH=8
module tb_alu_pipe;

    typedef struct {
        longint unsigned res;
        bit z, n, c, v, ill;
        int lat;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  op;
    logic        zero, neg, carry, ovf, illegal;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  op8;
    logic        zero8, neg8, carry8, ovf8, illegal8;

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .neg(neg),
        .carry(carry), .ovf(ovf), .illegal(illegal)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .zero(zero8), .neg(neg8),
        .carry(carry8), .ovf(ovf8), .illegal(illegal8)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   q32[$];
    exp_t   q8[$];
    bit     seen32 = 0, seen8 = 0;
    bit     rand_bp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on masked operands, signed views by two's-complement offset
    function automatic exp_t model(int w, bit [3:0] o, longint unsigned x, longint unsigned y);
        exp_t e;
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned r = 0, p;
        longint sa, sb, lo, hi;
        int sh;
        x &= mask;
        y &= mask;
        sa = ((x >> (w - 1)) & 1) ? longint'(x) - longint'(64'd1 << w) : longint'(x);
        sb = ((y >> (w - 1)) & 1) ? longint'(y) - longint'(64'd1 << w) : longint'(y);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        sh = int'(y % longint'(w));
        e.c = 0; e.v = 0; e.ill = 0; e.lat = 1; e.acc = 0;
        case (o)
            4'd0: begin r = x + y; e.c = (r >> w) != 0; e.v = (sa + sb < lo) || (sa + sb > hi); end
            4'd1: begin r = x - y; e.c = x < y; e.v = (sa - sb < lo) || (sa - sb > hi); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = x << sh;
            4'd6: r = x >> sh;
            4'd7: r = longint'(sa >>> sh);
            4'd8: r = (sa < sb) ? 1 : 0;
            4'd9: r = (x < y) ? 1 : 0;
            4'd10: begin p = x * y; r = p; e.v = (p >> w) != 0; e.lat = w; end
            default: begin r = 0; e.ill = 1; end
        endcase
        r &= mask;
        e.res = r;
        e.z = (r == 0);
        e.n = ((r >> (w - 1)) & 1) != 0;
        return e;
    endfunction

    task automatic issue(int w, bit [3:0] o, longint unsigned x, longint unsigned y);
        exp_t e;
        int t = 0;
        if (w == 32) begin in_valid = 1; op = o; a = x[31:0]; b = y[31:0]; end
        else         begin in_valid8 = 1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
        @(negedge clk);
        while (!(w == 32 ? in_ready : in_ready8) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout w=%0d: in_ready stayed 0, required 1", w);
        end else begin
            e = model(w, o, x, y);
            e.acc = cyc;
            if (w == 32) q32.push_back(e);
            else         q8.push_back(e);
        end
        @(posedge clk);
        #1;
        if (w == 32) in_valid = 0;
        else         in_valid8 = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() != 0 || q8.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0", q32.size(), q8.size());
            q32.delete();
            q8.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned rnd();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 64'hFFFF_FFFF;
            2: return 64'h8000_0000;
            3: return longint'($urandom_range(0, 40));
            default: return longint'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) seen32 = 0;
        else if (out_valid) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out32: out_valid=1 with result %0h, required no output", result);
            end else begin
                e = q32[0];
                if (!seen32) begin chk("lat32", longint'(cyc - e.acc), longint'(e.lat)); seen32 = 1; end
                chk("res32", result, e.res);
                chk("flags32 zncvi", {zero, neg, carry, ovf, illegal}, {e.z, e.n, e.c, e.v, e.ill});
                if (out_ready) begin void'(q32.pop_front()); seen32 = 0; end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) seen8 = 0;
        else if (out_valid8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: out_valid=1 with result %0h, required no output", result8);
            end else begin
                e = q8[0];
                if (!seen8) begin chk("lat8", longint'(cyc - e.acc), longint'(e.lat)); seen8 = 1; end
                chk("res8", result8, e.res);
                chk("flags8 zncvi", {zero8, neg8, carry8, ovf8, illegal8}, {e.z, e.n, e.c, e.v, e.ill});
                if (out_ready8) begin void'(q8.pop_front()); seen8 = 0; end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) begin
            out_ready  = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int bad;
        longint t0;
        rst = 1;
        in_valid = 0; a = 0; b = 0; op = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; op8 = 0; out_ready8 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset out_valid32", out_valid, 0);
        chk("reset result32", result, 0);
        chk("reset flags32", {zero, neg, carry, ovf, illegal}, 0);
        chk("reset in_ready32", in_ready, 1);
        chk("reset out_valid8", out_valid8, 0);
        chk("reset in_ready8", in_ready8, 1);
        @(posedge clk);
        #1;

        issue(32, 4'd0, 64'hFFFF_FFFF, 64'h1);
        issue(32, 4'd1, 64'h8000_0000, 64'h1);
        issue(32, 4'd1, 64'h1, 64'h2);
        issue(32, 4'd7, 64'h8000_0000, 64'h24);
        issue(32, 4'd8, 64'hFFFF_FFFF, 64'h1);
        issue(32, 4'd9, 64'hFFFF_FFFF, 64'h1);
        issue(32, 4'd15, 64'h5, 64'h6);
        drain();

        issue(32, 4'd10, 64'd12345, 64'd678);
        bad = 0;
        repeat (31) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad++;
        end
        chk("mul32 in_ready low cycles", bad, 0);
        issue(32, 4'd10, 64'h10000, 64'h10000);
        drain();

        out_ready = 0;
        issue(32, 4'd0, 64'd3, 64'd4);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || result !== 32'd7 || out_valid !== 1'b1) bad++;
        end
        chk("backpressure hold", bad, 0);
        @(posedge clk);
        #1 out_ready = 1;
        t0 = cyc;
        for (int i = 0; i < 10; i++) issue(32, 4'($urandom_range(0, 9)), rnd(), rnd());
        chk("stream throughput cycles", longint'(cyc - t0), 10);
        drain();

        issue(32, 4'd10, 64'd7, 64'd9);
        repeat (10) @(posedge clk);
        #1 rst = 1;
        q32.delete();
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("mul abort out_valid", out_valid, 0);
        chk("mul abort in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;

        issue(8, 4'd0, 64'hFF, 64'h01);
        issue(8, 4'd1, 64'h80, 64'h01);
        issue(8, 4'd7, 64'h80, 64'h0C);
        issue(8, 4'd10, 64'h10, 64'h10);
        issue(8, 4'd10, 64'd12, 64'd11);
        issue(8, 4'd15, 64'h1, 64'h1);
        drain();

        rand_bp = 1;
        for (int i = 0; i < 50; i++) issue(32, 4'($urandom_range(0, 15)), rnd(), rnd());
        for (int i = 0; i < 30; i++) issue(8, 4'($urandom_range(0, 15)), longint'($urandom_range(0, 255)),
                                           longint'($urandom_range(0, 255)));
        rand_bp = 0;
        @(posedge clk);
        #1 out_ready = 1;
        out_ready8 = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
